// File: rtl/dma_ctrl_if.sv
// Bus bundles for the DMA engine: the CPU-facing register port and the memory-facing master port.
interface dma_slv_if;
    logic        s_cs_;
    logic        s_as_;
    logic        s_rw;
    logic [1:0]  s_addr;
    logic [31:0] s_wr_data;
    logic [31:0] s_rd_data;
    logic        s_rdy_;

    modport master (output s_cs_, s_as_, s_rw, s_addr, s_wr_data, input s_rd_data, s_rdy_);
    modport slave  (input s_cs_, s_as_, s_rw, s_addr, s_wr_data, output s_rd_data, s_rdy_);
endinterface

interface dma_mst_if;
    logic        m_req_;
    logic        m_grnt_;
    logic        m_as_;
    logic        m_rw;
    logic [29:0] m_addr;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;
    logic        m_rdy_;

    modport master (output m_req_, m_as_, m_rw, m_addr, m_wr_data, input m_grnt_, m_rd_data, m_rdy_);
    modport slave  (input m_req_, m_as_, m_rw, m_addr, m_wr_data, output m_grnt_, m_rd_data, m_rdy_);
endinterface

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA: CPU-programmed SRC/DST/COUNT, one word per bus tenure,
// level interrupt on completion.
module dma_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      reset,
    dma_slv_if.slave  s_bus,
    dma_mst_if.master m_bus,
    output logic      irq
);
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT, FIN} state_e;

    state_e           state_q, state_d;
    logic [29:0]      src_q, src_d;
    logic [29:0]      dst_q, dst_d;
    logic [29:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             rdy_q, rdy_d;
    logic             irq_q, irq_d;

    logic busy, acc, wr_acc, gnt, mrdy;
    logic unused_wdata;

    assign busy   = (state_q != IDLE);
    assign acc    = !s_bus.s_cs_ && !s_bus.s_as_;
    assign wr_acc = acc && !s_bus.s_rw;
    assign gnt    = !m_bus.m_grnt_;
    assign mrdy   = gnt && !m_bus.m_rdy_;
    assign unused_wdata = ^s_bus.s_wr_data[31:30];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        ie_d      = ie_q;
        done_d    = done_q;
        abort_d   = abort_q;
        rdy_d     = !acc;
        rd_data_d = '0;
        irq_d     = done_q & ie_q;

        if (acc && s_bus.s_rw) begin
            case (s_bus.s_addr)
                2'd0: rd_data_d = {28'd0, 1'b0, done_q, ie_q, busy};
                2'd1: rd_data_d = {2'b00, src_q};
                2'd2: rd_data_d = {2'b00, dst_q};
                2'd3: rd_data_d = 32'(cnt_q);
            endcase
        end

        if (wr_acc) begin
            case (s_bus.s_addr)
                2'd0: begin
                    ie_d = s_bus.s_wr_data[1];
                    if (s_bus.s_wr_data[2]) done_d = 1'b0;
                    if (s_bus.s_wr_data[3] && busy) abort_d = 1'b1;
                    if (s_bus.s_wr_data[0] && !busy) begin
                        if (cnt_q == '0) done_d = 1'b1;
                        else             state_d = REQ;
                    end
                end
                2'd1: if (!busy) src_d = s_bus.s_wr_data[29:0];
                2'd2: if (!busy) dst_d = s_bus.s_wr_data[29:0];
                2'd3: if (!busy) cnt_d = s_bus.s_wr_data[CNT_W-1:0];
            endcase
        end

        // FSM updates come after register writes so a FIN-cycle DONE set beats a DONE clear.
        case (state_q)
            IDLE: ;
            REQ: begin
                if (gnt) begin
                    addr_d  = src_q;
                    state_d = RD;
                end
            end
            RD: begin
                if (mrdy) begin
                    buf_d   = m_bus.m_rd_data;
                    addr_d  = dst_q;
                    state_d = WR;
                end
            end
            WR: begin
                if (mrdy) begin
                    src_d   = src_q + 30'd1;
                    dst_d   = dst_q + 30'd1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: state_d = (cnt_q == '0 || abort_q) ? FIN : REQ;
            FIN: begin
                done_d  = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            rdy_q     <= 1'b1;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign m_bus.m_req_     = !(state_q == REQ || state_q == RD || state_q == WR);
    assign m_bus.m_as_      = !((state_q == RD || state_q == WR) && gnt);
    assign m_bus.m_rw       = (state_q != WR);
    assign m_bus.m_addr     = addr_q;
    assign m_bus.m_wr_data  = buf_q;
    assign s_bus.s_rd_data  = rd_data_q;
    assign s_bus.s_rdy_     = rdy_q;
    assign irq              = irq_q;
endmodule
